// File: rtl/reducao_pkg.sv
// Shared types and constants for the block-average downscaler.
package reducao_pkg;

    localparam int unsigned ACC_W     = 12;
    localparam int unsigned MAX_FATOR = 4;
    localparam int unsigned CNT_W     = $clog2(MAX_FATOR);
    localparam int unsigned SHIFT_W   = 3;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ACUM   = 2'd1,
        SAIDA  = 2'd2
    } estado_t;

    // log2(fator^2) for a given escala; illegal scales behave as fator = 1.
    function automatic logic [SHIFT_W-1:0] escala_shift(input logic [2:0] escala);
        case (escala)
            3'd2:    return SHIFT_W'(2);
            3'd4:    return SHIFT_W'(4);
            default: return SHIFT_W'(0);
        endcase
    endfunction

    // fator - 1, the last column/row index inside a block.
    function automatic logic [CNT_W-1:0] escala_lim(input logic [2:0] escala);
        case (escala)
            3'd2:    return CNT_W'(1);
            3'd4:    return CNT_W'(3);
            default: return CNT_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/media_divisor.sv
// Round-half-up divide of the block sum by fator^2 (a power of two).
module media_divisor
    import reducao_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ACC_W = reducao_pkg::ACC_W
) (
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [PIX_W-1:0]   media_o
);

    localparam int unsigned SOMA_W = ACC_W + 1;

    logic [SOMA_W-1:0] meio;
    logic [SOMA_W-1:0] soma;

    always_comb begin
        meio    = '0;
        if (shift_i != '0) begin
            meio = SOMA_W'(1) << (shift_i - SHIFT_W'(1));
        end
        soma    = SOMA_W'(acc_i) + meio;
        media_o = PIX_W'(soma >> shift_i);
    end

endmodule

// File: rtl/reducao_media.sv
// Block-average downscaler: one rounded mean per fator x fator block.
// Optional offset ordering check enabled by defining BLOCK_OFFSET_CHECK_EN.
module reducao_media #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ACC_W = reducao_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic [3:0]       offset_x,
    input  logic [3:0]       offset_y,
    input  logic [2:0]       escala,
    output logic             ready,
    output logic [PIX_W-1:0] pixel_out,
    output logic             done,
    output logic             erro
);

    import reducao_pkg::*;

    estado_t            estado_q, estado_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cont_x_q, cont_x_d;
    logic [CNT_W-1:0]   cont_y_q, cont_y_d;
    logic [CNT_W-1:0]   lim_q, lim_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               err_q, err_d;
    logic [PIX_W-1:0]   pixel_out_q;
    logic               done_q;
    logic               erro_q;
    logic [PIX_W-1:0]   media;
    logic               desvio;

`ifdef BLOCK_OFFSET_CHECK_EN
    // Counters hold the expected in-block position of the next pixel.
    assign desvio = (offset_x != 4'(cont_x_q)) || (offset_y != 4'(cont_y_q));
`else
    logic unused_offsets;
    assign desvio         = 1'b0;
    assign unused_offsets = ^{offset_x, offset_y};
`endif

    media_divisor #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) u_divisor (
        .acc_i   (acc_q),
        .shift_i (shift_q),
        .media_o (media)
    );

    // Next-state: accumulation, block position and sticky order flag.
    always_comb begin
        estado_d = estado_q;
        acc_d    = acc_q;
        cont_x_d = cont_x_q;
        cont_y_d = cont_y_q;
        lim_d    = lim_q;
        shift_d  = shift_q;
        err_d    = err_q;
        unique case (estado_q)
            OCIOSO: begin
                if (enable) begin
                    lim_d    = escala_lim(escala);
                    shift_d  = escala_shift(escala);
                    acc_d    = ACC_W'(pixel_in);
                    cont_x_d = CNT_W'(1);
                    cont_y_d = '0;
                    err_d    = desvio;
                    estado_d = (escala_lim(escala) == '0) ? SAIDA : ACUM;
                end
            end
            ACUM: begin
                if (enable) begin
                    acc_d = acc_q + ACC_W'(pixel_in);
                    err_d = err_q | desvio;
                    if (cont_x_q == lim_q) begin
                        cont_x_d = '0;
                        cont_y_d = cont_y_q + CNT_W'(1);
                        if (cont_y_q == lim_q) begin
                            estado_d = SAIDA;
                        end
                    end else begin
                        cont_x_d = cont_x_q + CNT_W'(1);
                    end
                end
            end
            SAIDA: begin
                acc_d    = '0;
                cont_x_d = '0;
                cont_y_d = '0;
                err_d    = 1'b0;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            acc_q       <= '0;
            cont_x_q    <= '0;
            cont_y_q    <= '0;
            lim_q       <= '0;
            shift_q     <= '0;
            err_q       <= 1'b0;
            pixel_out_q <= '0;
            done_q      <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q <= estado_d;
            acc_q    <= acc_d;
            cont_x_q <= cont_x_d;
            cont_y_q <= cont_y_d;
            lim_q    <= lim_d;
            shift_q  <= shift_d;
            err_q    <= err_d;
            done_q   <= (estado_q == SAIDA);
            erro_q   <= (estado_q == SAIDA) && err_q;
            if (estado_q == SAIDA) begin
                pixel_out_q <= media;
            end
        end
    end

    assign ready     = (estado_q != SAIDA);
    assign pixel_out = pixel_out_q;
    assign done      = done_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_reducao_media.sv
// Directed self-checking bench for reducao_media.
module tb_reducao_media;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] pixel_in;
    logic [3:0] offset_x;
    logic [3:0] offset_y;
    logic [2:0] escala;
    logic       ready;
    logic [7:0] pixel_out;
    logic       done;
    logic       erro;

    int checks = 0;
    int errors = 0;

`ifdef BLOCK_OFFSET_CHECK_EN
    localparam logic ERRO_ESPERADO = 1'b1;
`else
    localparam logic ERRO_ESPERADO = 1'b0;
`endif

    reducao_media dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pixel_in  (pixel_in),
        .offset_x  (offset_x),
        .offset_y  (offset_y),
        .escala    (escala),
        .ready     (ready),
        .pixel_out (pixel_out),
        .done      (done),
        .erro      (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [7:0] p, input logic [3:0] ox, input logic [3:0] oy,
                        input logic [2:0] esc);
        enable   = 1'b1;
        pixel_in = p;
        offset_x = ox;
        offset_y = oy;
        escala   = esc;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (pixel_out !== 8'd0) begin errors++; $display("FAIL reset_pixel_out: got %0d expected 0", pixel_out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (erro !== 1'b0) begin errors++; $display("FAIL reset_erro: got %b expected 0", erro); end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_media_2x2();
        logic [7:0] px [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        for (int i = 0; i < 4; i++) begin
            push(px[i], 4'(i % 2), 4'(i / 2), 3'd2);
            if (i < 3) begin
                checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++;
                    $display("FAIL m2x2_acum: done=%b ready=%b expected done=0 ready=1", done, ready); end
            end
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL m2x2_ready_saida: got %b expected 0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL m2x2_done_early: got %b expected 0", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL m2x2_done: got %b expected 1", done); end
        checks++; if (pixel_out !== 8'd25) begin errors++; $display("FAIL m2x2_pixel: got %0d expected 25", pixel_out); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL m2x2_ready_back: got %b expected 1", ready); end
        checks++; if (erro !== 1'b0) begin errors++; $display("FAIL m2x2_erro: got %b expected 0", erro); end
        idle();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL m2x2_done_pulse: got %b expected 0", done); end
        checks++; if (pixel_out !== 8'd25) begin errors++; $display("FAIL m2x2_pixel_hold: got %0d expected 25", pixel_out); end
    endtask

    task automatic test_media_4x4();
        int dones = 0;
        for (int i = 0; i < 16; i++) begin
            push(8'd255, 4'(i % 4), 4'(i / 4), 3'd4);
            if (done) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL m4x4_done_early: got %0d pulses expected 0", dones); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pixel_out !== 8'd255) begin errors++;
            $display("FAIL m4x4_max: done=%b pixel=%0d expected done=1 pixel=255", done, pixel_out); end
        idle();
        for (int i = 0; i < 16; i++) begin
            push((i == 15) ? 8'd15 : 8'd0, 4'(i % 4), 4'(i / 4), 3'd4);
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL m4x4_ready: got %b expected 0", ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pixel_out !== 8'd1) begin errors++;
            $display("FAIL m4x4_round: done=%b pixel=%0d expected done=1 pixel=1", done, pixel_out); end
        idle();
    endtask

    task automatic test_arredondamento();
        logic [7:0] px [4] = '{8'd1, 8'd2, 8'd2, 8'd2};
        for (int i = 0; i < 4; i++) push(px[i], 4'(i % 2), 4'(i / 2), 3'd2);
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pixel_out !== 8'd2) begin errors++;
            $display("FAIL round_2x2: done=%b pixel=%0d expected done=1 pixel=2", done, pixel_out); end
        idle();
        push(8'd77, 4'd0, 4'd0, 3'd3);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL esc3_ready: got %b expected 0", ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pixel_out !== 8'd77) begin errors++;
            $display("FAIL esc3_pixel: done=%b pixel=%0d expected done=1 pixel=77", done, pixel_out); end
        idle();
        push(8'd5, 4'd0, 4'd0, 3'd0);
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pixel_out !== 8'd5) begin errors++;
            $display("FAIL esc0_pixel: done=%b pixel=%0d expected done=1 pixel=5", done, pixel_out); end
        idle();
    endtask

    task automatic test_reset_meio();
        logic [7:0] px [4] = '{8'd0, 8'd0, 8'd0, 8'd4};
        int dones = 0;
        push(8'd200, 4'd0, 4'd0, 3'd2);
        push(8'd200, 4'd1, 4'd0, 3'd2);
        enable = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        checks++; if (ready !== 1'b1 || pixel_out !== 8'd0 || done !== 1'b0 || erro !== 1'b0) begin errors++;
            $display("FAIL rst_mid_outputs: ready=%b pixel=%0d done=%b erro=%b expected 1 0 0 0", ready, pixel_out, done, erro); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(px[i], 4'(i % 2), 4'(i / 2), 3'd2);
            if (done) dones++;
        end
        @(posedge clk); #1;
        if (done) dones++;
        checks++; if (pixel_out !== 8'd1) begin errors++; $display("FAIL rst_mid_pixel: got %0d expected 1", pixel_out); end
        for (int i = 0; i < 3; i++) begin
            idle();
            if (done) dones++;
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL rst_mid_dones: got %0d expected 1", dones); end
    endtask

    task automatic test_erro_offset();
        logic [3:0] ox [4] = '{4'd0, 4'd0, 4'd1, 4'd1};
        logic [3:0] oy [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
        for (int i = 0; i < 4; i++) begin
            push(8'(4 * (i + 1)), ox[i], oy[i], 3'd2);
            if (i < 3) begin
                checks++; if (erro !== 1'b0) begin errors++; $display("FAIL erro_early: got %b expected 0", erro); end
            end
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pixel_out !== 8'd10) begin errors++;
            $display("FAIL erro_media: done=%b pixel=%0d expected done=1 pixel=10", done, pixel_out); end
        checks++; if (erro !== ERRO_ESPERADO) begin errors++; $display("FAIL erro_flag: got %b expected %b", erro, ERRO_ESPERADO); end
        idle();
        checks++; if (erro !== 1'b0) begin errors++; $display("FAIL erro_pulse: got %b expected 0", erro); end
        for (int i = 0; i < 4; i++) push(8'd8, 4'(i % 2), 4'(i / 2), 3'd2);
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || erro !== 1'b0) begin errors++;
            $display("FAIL erro_cleared: done=%b erro=%b expected done=1 erro=0", done, erro); end
        idle();
    endtask

    task automatic test_escala_muda();
        push(8'd100, 4'd0, 4'd0, 3'd2);
        push(8'd100, 4'd1, 4'd0, 3'd4);
        push(8'd100, 4'd0, 4'd1, 3'd4);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL esc_muda_mid: ready=%b expected 1", ready); end
        push(8'd104, 4'd1, 4'd1, 3'd4);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL esc_muda_close: ready=%b expected 0", ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pixel_out !== 8'd101) begin errors++;
            $display("FAIL esc_muda_pixel: done=%b pixel=%0d expected done=1 pixel=101", done, pixel_out); end
        idle();
    endtask

    task automatic test_back_to_back();
        push(8'd3, 4'd0, 4'd0, 3'd1);
        pixel_in = 8'd9;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready0: got %b expected 0", ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pixel_out !== 8'd3 || ready !== 1'b1) begin errors++;
            $display("FAIL b2b_first: done=%b pixel=%0d ready=%b expected 1 3 1", done, pixel_out, ready); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || ready !== 1'b0) begin errors++;
            $display("FAIL b2b_accept: done=%b ready=%b expected done=0 ready=0", done, ready); end
        enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || pixel_out !== 8'd9) begin errors++;
            $display("FAIL b2b_second: done=%b pixel=%0d expected done=1 pixel=9", done, pixel_out); end
        idle();
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        pixel_in = '0;
        offset_x = '0;
        offset_y = '0;
        escala   = 3'd1;
        #1;
        test_reset();
        test_media_2x2();
        test_media_4x4();
        test_arredondamento();
        test_reset_meio();
        test_erro_offset();
        test_escala_muda();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
